exc_req_ctrl: RTL and testbench
===============================

Name: exc_req_ctrl

Overview:
Upstream exception-request front end for the CP0 block. It synchronises three asynchronous exception/interrupt lines and edge-detects them into sticky pending bits. It presents exactly one request at a time, one-hot on exp_src[2:0], so the CP0 cause encoding stays unambiguous. It then tracks the acknowledge/ERET handshake so a source is serviced once per edge.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (legal values 2..3).
ACK_TIMEOUT, 15, cycles a request is held without acknowledge before it is withdrawn (legal values 1..255).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
irq_in  in  3  raw exception lines, asynchronous, active-high.
exp_block  in  1  CP0 status[0]; 1 = exceptions blocked.
exp_ack  in  1  CP0 HasExp, sampled at the rising edge of clk.
is_eret  in  1  ERET decoded in the current instruction; sampled at the rising edge of clk.
exp_src  out  3  one-hot request to CP0 expSrc0..2; all zeros when idle.
pending  out  3  sticky pending bits, visible for debug and the testbench.
busy  out  1  high while in REQ or SERVICE.
timeout  out  1  one-cycle pulse when a request is withdrawn for lack of acknowledge.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser chain, edge register, pending, exp_src, busy, timeout and the counter all go to 0. The state machine goes to IDLE.
- Synchroniser: irq_in passes through SYNC_STAGES flops to give s. rise = s & ~s_prev.
- Capture latency: an irq_in rising edge sets pending[i] SYNC_STAGES+1 clocks later. Levels are ignored; only edges count.
- A second edge on a bit that is already pending is absorbed, so there is no counting.
- pending[i] clears only when source i's request is acknowledged. If a new rise on i arrives in the same cycle as that clear, the set wins and the bit stays 1.
- Priority: index 0 is highest, index 2 is lowest.
- State machine, states IDLE, REQ, SERVICE, all evaluated at the rising edge of clk:
  - IDLE, when pending != 0 and exp_block == 0: latch cur = index of the highest-priority pending bit, drive exp_src = onehot(cur), load cnt = ACK_TIMEOUT, go to REQ.
  - IDLE, when exp_block == 1: stay in IDLE. pending is retained.
  - REQ, when exp_ack == 1: clear pending[cur], set exp_src = 0, go to SERVICE.
  - REQ, when exp_ack == 0 and cnt == 1: set exp_src = 0, pulse timeout for one cycle, go to IDLE. pending[cur] is kept, so the request is retried.
  - REQ, otherwise: decrement cnt. exp_src stays constant during REQ, even if a higher-priority bit becomes pending.
  - REQ, when exp_block rises: exp_src is still held; the CP0 gates it.
  - SERVICE, when is_eret == 1: go to IDLE. A new request can be issued on the next cycle at the earliest.
  - SERVICE, when exp_ack == 1: ignored.
- busy = (state != IDLE), registered.
- exp_src is registered, changes only on clk edges and never has more than one bit set.
- Simultaneous exp_ack and cnt == 1 in REQ: the acknowledge wins and no timeout is raised.
- Reset asserted mid-REQ: exp_src drops to 0 immediately (asynchronously). All pending state is lost.

Decomposition:
- Shared package holds:
  - localparams for state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - NUM_EXC_SRC = 3.
  - a priority-encode function returning the index and a valid flag.
- One sub-module is natural: exc_sync_edge. It contains the SYNC_STAGES synchroniser plus the rising-edge detector, one per bit, and takes the same clk/rst_n.

Test Plan:
1. Reset, then pulse irq_in = 3'b010 for one cycle, with exp_block = 0. Required: pending = 010 after 3 clocks, then exp_src = 010 and busy = 1 on the next clock. Assert exp_ack for one cycle: exp_src = 000 and pending = 000. Drive is_eret: busy = 0 on the next clock.
2. Raise irq_in = 3'b101 together. Required: exp_src = 001 first. After ack + ERET, exp_src = 100 is issued. pending goes 101 → 100 → 000.
3. Hold exp_block = 1 and pulse irq_in[2]. Required: pending = 100 and exp_src stays 000 indefinitely. Release exp_block: exp_src = 100 one clock later.
4. With ACK_TIMEOUT = 15, issue a request and never ack. Required: exp_src is held for exactly 15 cycles, then a 1-cycle timeout pulse, pending retained, and the request reissued the next cycle.
5. Hold irq_in[0] high for 50 cycles. Required: only one service for source 0, and no re-pend after the ack. Pulse irq_in[0] again during SERVICE: pending[0] = 1 again and it is served after the ERET.
6. Drop rst_n mid-REQ, between clock edges. Required: exp_src = 000 immediately and pending = 000. After release, with no new edge, there is no request.

Source files
------------

// File: rtl/exc_req_ctrl_pkg.sv
// Shared types for the CP0 exception-request front end: state encoding,
// source count and the fixed-priority encoder used to pick the next source.
package exc_req_ctrl_pkg;

  localparam int NUM_EXC_SRC = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } prio_t;

  // Index 0 is the highest priority, so scan downwards and let lower indices overwrite.
  function automatic prio_t prio_enc(input logic [NUM_EXC_SRC-1:0] req);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = 2'd0;
    for (int i = NUM_EXC_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/exc_sync_edge.sv
// Multi-flop synchroniser for asynchronous lines followed by a rising-edge
// detector; rise is combinational from the last sync stage and its delayed copy.
module exc_sync_edge #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_prev;

endmodule

// File: rtl/exc_req_ctrl.sv
// Exception-request front end: captures synchronised edges into sticky pending
// bits and offers one source at a time to CP0 through an ack/ERET handshake.
module exc_req_ctrl
  import exc_req_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_EXC_SRC-1:0] irq_in,
  input  logic                   exp_block,
  input  logic                   exp_ack,
  input  logic                   is_eret,
  output logic [NUM_EXC_SRC-1:0] exp_src,
  output logic [NUM_EXC_SRC-1:0] pending,
  output logic                   busy,
  output logic                   timeout
);

  // Handshake: exp_src is the request (held constant through REQ); exp_ack in REQ
  // accepts it and clears that pending bit; is_eret in SERVICE closes it. A request
  // left unacknowledged for ACK_TIMEOUT cycles is withdrawn and retried from IDLE.

  localparam logic [7:0] CNT_INIT = 8'(ACK_TIMEOUT);

  logic [NUM_EXC_SRC-1:0] rise;
  logic [NUM_EXC_SRC-1:0] clr;
  state_t                 state;
  logic [1:0]             cur;
  logic [7:0]             cnt;
  prio_t                  sel;

  exc_sync_edge #(
    .WIDTH       (NUM_EXC_SRC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (irq_in),
    .rise  (rise)
  );

  assign sel = prio_enc(pending);

  always_comb begin
    clr = '0;
    if (state == REQ && exp_ack) clr[cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= 2'd0;
      cnt     <= 8'd0;
      pending <= '0;
      exp_src <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // A fresh edge in the same cycle as the clear keeps the bit set.
      pending <= (pending & ~clr) | rise;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sel.valid && !exp_block) begin
            cur     <= sel.idx;
            exp_src <= NUM_EXC_SRC'(1) << sel.idx;
            cnt     <= CNT_INIT;
            state   <= REQ;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (exp_ack) begin
            exp_src <= '0;
            state   <= SERVICE;
          end else if (cnt == 8'd1) begin
            exp_src <= '0;
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SERVICE: begin
          if (is_eret) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          exp_src <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_req_ctrl.sv
// Bench for exc_req_ctrl: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_exc_req_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] irq_in;
  logic       exp_block, exp_ack, is_eret;
  logic [2:0] exp_src, pending;
  logic       busy, timeout;

  int total = 0;
  int bad   = 0;

  exc_req_ctrl #(.SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .exp_block (exp_block),
    .exp_ack   (exp_ack),
    .is_eret   (is_eret),
    .exp_src   (exp_src),
    .pending   (pending),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: a line history queue, sticky pending set, and the active
  // request described as (source, cycles left) or an open service.
  logic [2:0] hist[$];
  logic [2:0] m_pend;
  int         m_req;
  int         m_left;
  bit         m_svc;
  bit         m_to;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back(3'b000);
    m_pend = 3'b000;
    m_req  = -1;
    m_left = 0;
    m_svc  = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] irq, input logic blk, input logic ack,
                            input logic eret);
    logic [2:0] rise;
    logic [2:0] clr;
    rise = hist[SYNC-1] & ~hist[SYNC];
    hist.push_front(irq);
    void'(hist.pop_back());
    clr  = 3'b000;
    m_to = 1'b0;
    if (m_svc) begin
      if (eret) m_svc = 1'b0;
    end else if (m_req >= 0) begin
      if (ack) begin
        clr[m_req] = 1'b1;
        m_svc = 1'b1;
        m_req = -1;
      end else if (m_left == 1) begin
        m_to  = 1'b1;
        m_req = -1;
      end else begin
        m_left--;
      end
    end else if (m_pend != 3'b000 && !blk) begin
      for (int i = 2; i >= 0; i--) if (m_pend[i]) m_req = i;
      m_left = TMO;
    end
    m_pend = (m_pend & ~clr) | rise;
  endtask

  function automatic logic [2:0] m_src();
    return (m_req >= 0) ? 3'(1 << m_req) : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive at the falling edge, advance model on the rising edge, check at the next falling edge.
  task automatic cycle(input logic [2:0] irq, input logic blk, input logic ack, input logic eret);
    irq_in = irq; exp_block = blk; exp_ack = ack; is_eret = eret;
    @(posedge clk);
    model_edge(irq, blk, ack, eret);
    @(negedge clk);
    chk("pending", pending, m_pend);
    chk("exp_src", exp_src, m_src());
    chk("busy", busy, (m_req >= 0 || m_svc));
    chk("timeout", timeout, m_to);
    chk("onehot", ($countones(exp_src) <= 1), 1);
  endtask

  int n;
  logic [2:0] rirq;
  logic rblk, rack, reret;

  initial begin
    rst_n = 1'b0; irq_in = '0; exp_block = 0; exp_ack = 0; is_eret = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_exp_src", exp_src, 3'b000);
    chk("rst_pending", pending, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // Single pulse on source 1.
    cycle(3'b010, 0, 0, 0);
    cycle(3'b000, 0, 0, 0);
    cycle(3'b000, 0, 0, 0);
    chk("t1_pend", pending, 3'b010);
    cycle(3'b000, 0, 0, 0);
    chk("t1_src", exp_src, 3'b010);
    chk("t1_busy", busy, 1);
    cycle(3'b000, 0, 1, 0);
    chk("t1_ack_src", exp_src, 3'b000);
    chk("t1_ack_pend", pending, 3'b000);
    cycle(3'b000, 0, 0, 1);
    chk("t1_eret_busy", busy, 0);

    // Two sources at once: 0 wins, then 2.
    cycle(3'b101, 0, 0, 0);
    repeat (3) cycle(3'b000, 0, 0, 0);
    chk("t2_first", exp_src, 3'b001);
    cycle(3'b000, 0, 1, 0);
    chk("t2_pend_mid", pending, 3'b100);
    cycle(3'b000, 0, 0, 1);
    cycle(3'b000, 0, 0, 0);
    chk("t2_second", exp_src, 3'b100);
    cycle(3'b000, 0, 1, 0);
    chk("t2_pend_end", pending, 3'b000);
    cycle(3'b000, 0, 0, 1);

    // Timeout: held exactly TMO cycles, one-cycle pulse, reissue.
    cycle(3'b001, 0, 0, 0);
    repeat (3) cycle(3'b000, 0, 0, 0);
    n = (exp_src != 3'b000) ? 1 : 0;
    for (int k = 0; k < 40 && exp_src != 3'b000; k++) begin
      cycle(3'b000, 0, 0, 0);
      if (exp_src != 3'b000) n++;
    end
    chk("t4_hold_cycles", n, TMO);
    chk("t4_timeout", timeout, 1);
    chk("t4_pend_kept", pending, 3'b001);
    cycle(3'b000, 0, 0, 0);
    chk("t4_reissue", exp_src, 3'b001);
    cycle(3'b000, 0, 1, 0);
    cycle(3'b000, 0, 0, 1);

    // Blocked: pending held, no request until released.
    cycle(3'b100, 1, 0, 0);
    repeat (10) cycle(3'b000, 1, 0, 0);
    chk("t3_blocked_src", exp_src, 3'b000);
    chk("t3_blocked_pend", pending, 3'b100);
    cycle(3'b000, 0, 0, 0);
    chk("t3_release", exp_src, 3'b100);
    cycle(3'b000, 0, 1, 0);
    cycle(3'b000, 0, 0, 1);

    // Level held high: served once only.
    n = 0;
    for (int k = 0; k < 50; k++) begin
      rack  = (exp_src != 3'b000);
      reret = busy && (exp_src == 3'b000);
      if (rack) n++;
      cycle(3'b001, 0, rack, reret);
    end
    chk("t5_services", n, 1);
    chk("t5_no_repend", pending, 3'b000);
    cycle(3'b000, 0, 0, 0);

    // Async reset mid-REQ.
    cycle(3'b010, 0, 0, 0);
    repeat (3) cycle(3'b000, 0, 0, 0);
    chk("t6_in_req", exp_src, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_src", exp_src, 3'b000);
    chk("t6_rst_pend", pending, 3'b000);
    chk("t6_rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle(3'b000, 0, 0, 0);

    // Random traffic.
    rirq = 3'b000; rblk = 1'b0;
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) rirq[b] = ~rirq[b];
      if ($urandom_range(0, 19) == 0) rblk = ~rblk;
      rack  = (m_req >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      reret = m_svc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      cycle(rirq, rblk, rack, reret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
